// File: rtl/scan_pkg.sv
// scan_pkg: shared mode encodings, reset pattern and scan direction type
// for the scan_sequencer block.
package scan_pkg;

    localparam logic [1:0] MODE_RING_L  = 2'b00;
    localparam logic [1:0] MODE_RING_R  = 2'b01;
    localparam logic [1:0] MODE_JOHNSON = 2'b10;
    localparam logic [1:0] MODE_BOUNCE  = 2'b11;

    // Bit 0 active after reset/reload; sliced to WIDTH by the user.
    localparam logic [63:0] RESET_PAT = 64'd1;

    typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_e;

endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: divides clk down to a one-cycle tick every DIV enabled
// cycles; clear reloads the count, enable low freezes it.
module scan_prescaler #(
    parameter int DIV = 12500000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = enable && (cnt_q == CW'(DIV - 1));

    always_comb
        cnt_d = clear ? '0 : !enable ? cnt_q : tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;

endmodule

// File: rtl/scan_sequencer.sv
// scan_sequencer: one-hot ring / Johnson / bounce scan bus generator with
// step strobe and index. Optional blanking after each step: SCAN_BLANK_EN.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DIV          = 12500000,
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int BLANK_CYCLES = 1000,
    localparam int IW          = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             restart,
    output logic [WIDTH-1:0] scan_out,
    output logic [IW-1:0]    index,
    output logic             step
);

    logic [WIDTH-1:0] pat_q, pat_d, scan_out_q, scan_out_d;
    logic [IW-1:0]    index_q, index_d, idx_inc, idx_dec;
    logic [1:0]       mode_q;
    dir_e             dir_q, dir_d, bdir;
    logic             step_q, tick, reload, advance, blanking;

    assign reload  = restart || (mode != mode_q);
    assign advance = tick && !reload;

    scan_prescaler #(.DIV(DIV)) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clear  (reload),
        .tick   (tick)
    );

    always_comb begin
        idx_inc = (index_q == IW'(WIDTH - 1)) ? '0 : index_q + 1'b1;
        idx_dec = (index_q == '0) ? IW'(WIDTH - 1) : index_q - 1'b1;
        // Bounce turns around on the edge bit so end positions are not repeated.
        bdir    = (dir_q == DIR_LEFT) ? (pat_q[WIDTH-1] ? DIR_RIGHT : DIR_LEFT)
                                      : (pat_q[0] ? DIR_LEFT : DIR_RIGHT);
        pat_d   = pat_q;
        index_d = index_q;
        dir_d   = dir_q;
        if (reload) begin
            pat_d   = RESET_PAT[WIDTH-1:0];
            index_d = '0;
            dir_d   = DIR_LEFT;
        end else if (advance) begin
            case (mode_q)
                MODE_RING_L: begin
                    pat_d   = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
                    index_d = idx_inc;
                end
                MODE_RING_R: begin
                    pat_d   = {pat_q[0], pat_q[WIDTH-1:1]};
                    index_d = idx_dec;
                end
                MODE_JOHNSON: begin
                    pat_d   = {pat_q[WIDTH-2:0], ~pat_q[WIDTH-1]};
                    index_d = idx_inc;
                end
                default: begin
                    dir_d   = bdir;
                    pat_d   = (bdir == DIR_LEFT) ? pat_q << 1 : pat_q >> 1;
                    index_d = (bdir == DIR_LEFT) ? idx_inc : idx_dec;
                end
            endcase
        end
    end

`ifdef SCAN_BLANK_EN
    localparam int BW = $clog2(BLANK_CYCLES + 2);

    logic [BW-1:0] blank_q, blank_d;

    always_comb
        blank_d = reload ? '0
                : advance ? BW'(BLANK_CYCLES)
                : (enable && blank_q != '0) ? blank_q - 1'b1 : blank_q;

    always_ff @(posedge clk or negedge reset)
        if (!reset) blank_q <= '0;
        else        blank_q <= blank_d;

    assign blanking = (blank_d != '0);
`else
    // Blanking compiled out; the parameter stays for a uniform interface.
    assign blanking = (BLANK_CYCLES < 0);
`endif

    always_comb
        scan_out_d = {WIDTH{ACTIVE_LOW}} ^ (blanking ? '0 : pat_d);

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            pat_q      <= RESET_PAT[WIDTH-1:0];
            index_q    <= '0;
            dir_q      <= DIR_LEFT;
            mode_q     <= MODE_RING_L;
            step_q     <= 1'b0;
            scan_out_q <= {WIDTH{ACTIVE_LOW}} ^ RESET_PAT[WIDTH-1:0];
        end else begin
            pat_q      <= pat_d;
            index_q    <= index_d;
            dir_q      <= dir_d;
            mode_q     <= mode;
            step_q     <= advance;
            scan_out_q <= scan_out_d;
        end

    assign scan_out = scan_out_q;
    assign index    = index_q;
    assign step     = step_q;

endmodule

// File: doc/scan_sequencer.md
# scan_sequencer

- Parametrised display/LED scan sequencer.
- Divides the system clock to a programmable step rate and drives a WIDTH-bit scan bus.
- Patterns: rotating one-hot (left or right), Johnson (twisted ring), or bounce (ping-pong).
- Adds selectable output polarity, an enable/hold input, a synchronous restart, and a per-step strobe and index for downstream segment muxing.

## Interface
Parameters:
- WIDTH, 8: number of scan lines; must be 2 or more.
- DIV, 12500000: clk cycles per step; must be 1 or more.
- ACTIVE_LOW, 1: 1 means an active line is driven 0 and idle lines 1; 0 means the reverse.
- BLANK_CYCLES, 1000: blanking length in clk cycles; used only with SCAN_BLANK_EN; must be less than DIV.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  high means the prescaler runs and the pattern advances; low holds both.
- mode  in  2  00 ring-left, 01 ring-right, 10 Johnson, 11 bounce.
- restart  in  1  synchronous reload of the pattern and prescaler.
- scan_out  out  WIDTH  registered scan lines; polarity set by ACTIVE_LOW.
- index  out  IW  registered step index; IW = clog2(WIDTH).
- step  out  1  one-cycle pulse in the cycle a new pattern takes effect.

## Operation
- Internal logical pattern `pat` is active-high; scan_out = ACTIVE_LOW ? ~pat : pat.
- Reset and reload state: pat = 1 (bit0 active), index = 0, direction = left, prescaler = 0, step = 0, mode_q = 00. With ACTIVE_LOW=1 and WIDTH=8, scan_out resets to 8'hFE.
- Prescaler counts 0..DIV-1 while enable=1. tick = enable && cnt == DIV-1; cnt then wraps to 0. Exact period is DIV cycles, with no off-by-one. DIV=1 gives a tick every enabled cycle.
- On each tick the pattern advances according to mode:
  - ring-left: pat rotates left; index = index+1 mod WIDTH.
  - ring-right: pat rotates right; index = index-1 mod WIDTH. Wrap 0 goes to WIDTH-1.
  - Johnson: pat = {pat[WIDTH-2:0], ~pat[WIDTH-1]}; period 2*WIDTH. index counts 0..WIDTH-1 cyclically, +1 per step.
  - bounce: one-hot moves in the current direction. The direction flips when the active bit reaches bit WIDTH-1 (moving left) or bit 0 (moving right). End positions are not repeated; period 2*WIDTH-2. index = active bit position.
- Mode change: mode is registered into mode_q every cycle. If mode != mode_q, the next edge performs a reload (reload state above). That edge gives no step and no advance.
- Priority, highest first: reset, restart, mode-change reload, tick, hold.
  - restart coincident with a tick: reload wins, step=0.
  - enable low mid-count: cnt, pat, index and direction freeze; counting resumes from the frozen cnt.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- A tick sampled at edge N updates scan_out and index after edge N, and step=1 for exactly that one cycle.
- restart or reload sampled at edge N: reload values are visible after edge N.
- From a reload with enable held high, the first step occurs DIV cycles later.

## Configuration
- Macro: SCAN_BLANK_EN.
- Defined:
  - A blank counter is loaded with BLANK_CYCLES on every advancing edge.
  - While the counter is nonzero, scan_out is forced all-inactive (all 1 when ACTIVE_LOW=1). This covers BLANK_CYCLES cycles starting with the step cycle; the new pattern appears afterwards.
  - index and step are unaffected.
  - Reset and reload clear the blank counter.
  - enable low also freezes the blank counter.
- Undefined: no blank logic; BLANK_CYCLES is ignored; scan_out reflects pat directly.

## Structure
- Package scan_pkg holds:
  - mode localparams MODE_RING_L, MODE_RING_R, MODE_JOHNSON, MODE_BOUNCE (2 bits);
  - the reset pattern constant.
- Sub-module scan_prescaler:
  - parameter DIV; inputs clk, reset, enable, clear; output tick;
  - counter width clog2(DIV), minimum 1.
- Top level: pattern/index/direction registers, mode_q, the output polarity stage, and the optional blank counter.

## Test plan
All scenarios use WIDTH=4, DIV=4, ACTIVE_LOW=1.
1. Reset, then ring-left with enable=1 -> scan_out 1110 at reset, then 1101, 1011, 0111, 1110 every 4 cycles. step pulses 1 cycle each; index 1, 2, 3, 0.
2. Ring-right from reset -> 1110, 0111, 1011, 1101, 1110. index 3, 2, 1, 0.
3. Johnson -> 1110, 1100, 1000, 0000, 0001, 0011, 0111, 1111, 1110; repeats with period 8.
4. Bounce -> active bit positions 0, 1, 2, 3, 2, 1, 0, 1. index matches the position and there are no repeated endpoints.
5. Control interactions:
   - enable low for 10 cycles after cnt=2 -> no change; the next step arrives 2 cycles after enable rises.
   - restart coincident with a tick -> 1110, step=0.
   - mode change mid-run -> reload on the next edge.
   - reset asserted mid-step -> immediate 1110.
6. With SCAN_BLANK_EN, BLANK_CYCLES=2 -> after each step scan_out=1111 for 2 cycles, then the new pattern. step and index are unaffected.
